// File: rtl/mem_bus_arbiter.sv
// Arbiter for the shared 8-bit memory bus: fetch (read-only) and execute (read/write) ports,
// registered request/ready handshakes, and a fetch-owned bus lock with an idle timeout.
module mem_bus_arbiter #(
    parameter bit          EXEC_FIRST   = 1'b1,
    parameter int unsigned LOCK_TIMEOUT = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       f_req,
    input  logic [7:0] f_addr,
    input  logic       f_lock,
    output logic       f_ready,
    output logic [7:0] f_rdata,
    input  logic       e_req,
    input  logic [7:0] e_addr,
    input  logic       e_we,
    input  logic [7:0] e_wdata,
    output logic       e_ready,
    output logic [7:0] e_rdata,
    output logic       mem_req,
    output logic [7:0] mem_addr,
    output logic       mem_we,
    output logic       mem_oe,
    output logic [7:0] mem_wdata,
    input  logic [7:0] mem_rdata,
    input  logic       mem_ready,
    output logic [1:0] owner
);
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [1:0] OWN_NONE = 2'b00;
    localparam logic [1:0] OWN_F    = 2'b01;
    localparam logic [1:0] OWN_E    = 2'b10;
    localparam logic [7:0] TMO_LAST = 8'(LOCK_TIMEOUT - 1);

    state_t     state_q, state_d;
    logic [1:0] owner_q, owner_d;
    logic       lock_q, lock_d;
    logic       lock_at_grant_q, lock_at_grant_d;
    logic [7:0] tmo_q, tmo_d;
    logic       mem_req_q, mem_req_d;
    logic       mem_we_q, mem_we_d;
    logic       mem_oe_q, mem_oe_d;
    logic [7:0] mem_addr_q, mem_addr_d;
    logic [7:0] mem_wdata_q, mem_wdata_d;
    logic       f_ready_q, f_ready_d;
    logic       e_ready_q, e_ready_d;
    logic [7:0] f_rdata_q, f_rdata_d;
    logic [7:0] e_rdata_q, e_rdata_d;
    logic       grant_f_s, grant_e_s;

    // IDLE-cycle arbitration; a held lock shuts execute out entirely.
    assign grant_f_s = f_req && (lock_q || !e_req || !EXEC_FIRST);
    assign grant_e_s = e_req && !lock_q && (!f_req || EXEC_FIRST);

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q         <= IDLE;
            owner_q         <= OWN_NONE;
            lock_q          <= 1'b0;
            lock_at_grant_q <= 1'b0;
            tmo_q           <= 8'd0;
            mem_req_q       <= 1'b0;
            mem_we_q        <= 1'b0;
            mem_oe_q        <= 1'b0;
            mem_addr_q      <= 8'd0;
            mem_wdata_q     <= 8'd0;
            f_ready_q       <= 1'b0;
            e_ready_q       <= 1'b0;
            f_rdata_q       <= 8'd0;
            e_rdata_q       <= 8'd0;
        end else begin
            state_q         <= state_d;
            owner_q         <= owner_d;
            lock_q          <= lock_d;
            lock_at_grant_q <= lock_at_grant_d;
            tmo_q           <= tmo_d;
            mem_req_q       <= mem_req_d;
            mem_we_q        <= mem_we_d;
            mem_oe_q        <= mem_oe_d;
            mem_addr_q      <= mem_addr_d;
            mem_wdata_q     <= mem_wdata_d;
            f_ready_q       <= f_ready_d;
            e_ready_q       <= e_ready_d;
            f_rdata_q       <= f_rdata_d;
            e_rdata_q       <= e_rdata_d;
        end
    end

    // Next-state and next-output logic for the IDLE/BUSY/DONE beat sequence.
    always_comb begin
        state_d         = state_q;
        owner_d         = owner_q;
        lock_d          = lock_q;
        lock_at_grant_d = lock_at_grant_q;
        tmo_d           = tmo_q;
        mem_req_d       = mem_req_q;
        mem_we_d        = mem_we_q;
        mem_oe_d        = mem_oe_q;
        mem_addr_d      = mem_addr_q;
        mem_wdata_d     = mem_wdata_q;
        f_ready_d       = 1'b0;
        e_ready_d       = 1'b0;
        f_rdata_d       = f_rdata_q;
        e_rdata_d       = e_rdata_q;

        case (state_q)
            IDLE: begin
                if (grant_e_s) begin
                    state_d         = BUSY;
                    owner_d         = OWN_E;
                    lock_at_grant_d = 1'b0;
                    mem_req_d       = 1'b1;
                    mem_addr_d      = e_addr;
                    mem_we_d        = e_we;
                    mem_oe_d        = e_we;
                    mem_wdata_d     = e_wdata;
                end else if (grant_f_s) begin
                    state_d         = BUSY;
                    owner_d         = OWN_F;
                    lock_at_grant_d = f_lock;
                    tmo_d           = 8'd0;
                    mem_req_d       = 1'b1;
                    mem_addr_d      = f_addr;
                    mem_we_d        = 1'b0;
                    mem_oe_d        = 1'b0;
                    mem_wdata_d     = 8'd0;
                end else if (lock_q) begin
                    // Owner went quiet while holding the bus: count toward forced release.
                    if (tmo_q == TMO_LAST) begin
                        lock_d  = 1'b0;
                        tmo_d   = 8'd0;
                        owner_d = OWN_NONE;
                    end else begin
                        tmo_d = tmo_q + 8'd1;
                    end
                end else begin
                    state_d = IDLE;
                end
            end
            BUSY: begin
                if (mem_ready) begin
                    state_d   = DONE;
                    mem_req_d = 1'b0;
                    mem_we_d  = 1'b0;
                    mem_oe_d  = 1'b0;
                    if (owner_q == OWN_E) begin
                        e_ready_d = 1'b1;
                        if (!mem_we_q) begin
                            e_rdata_d = mem_rdata;
                        end else begin
                            e_rdata_d = e_rdata_q;
                        end
                    end else begin
                        f_ready_d = 1'b1;
                        f_rdata_d = mem_rdata;
                    end
                end else begin
                    state_d = BUSY;
                end
            end
            DONE: begin
                state_d = IDLE;
                lock_d  = (owner_q == OWN_F) && lock_at_grant_q;
                if ((owner_q == OWN_F) && lock_at_grant_q) begin
                    owner_d = OWN_F;
                end else begin
                    owner_d = OWN_NONE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign f_ready   = f_ready_q;
    assign f_rdata   = f_rdata_q;
    assign e_ready   = e_ready_q;
    assign e_rdata   = e_rdata_q;
    assign mem_req   = mem_req_q;
    assign mem_addr  = mem_addr_q;
    assign mem_we    = mem_we_q;
    assign mem_oe    = mem_oe_q;
    assign mem_wdata = mem_wdata_q;
    assign owner     = owner_q;
endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Bench for mem_bus_arbiter: directed scenarios plus random traffic, every cycle checked
// against a transaction-level model of the arbiter and a bench-owned memory array.
module tb_mem_bus_arbiter;
    localparam int TMO = 8;
    localparam bit EF  = 1'b1;

    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic rst;

    logic       f_req, f_lock, f_ready, e_req, e_we, e_ready;
    logic [7:0] f_addr, f_rdata, e_addr, e_wdata, e_rdata;
    logic       mem_req, mem_we, mem_oe, mem_ready;
    logic [7:0] mem_addr, mem_wdata, mem_rdata;
    logic [1:0] owner;

    logic       b_f_req, b_f_lock, b_f_ready, b_e_req, b_e_we, b_e_ready;
    logic [7:0] b_f_addr, b_f_rdata, b_e_addr, b_e_wdata, b_e_rdata;
    logic       b_mem_req, b_mem_we, b_mem_oe, b_mem_ready;
    logic [7:0] b_mem_addr, b_mem_wdata, b_mem_rdata;
    logic [1:0] b_owner;

    mem_bus_arbiter #(.EXEC_FIRST(1'b1), .LOCK_TIMEOUT(TMO)) dut (
        .clk(clk), .rst(rst),
        .f_req(f_req), .f_addr(f_addr), .f_lock(f_lock), .f_ready(f_ready), .f_rdata(f_rdata),
        .e_req(e_req), .e_addr(e_addr), .e_we(e_we), .e_wdata(e_wdata),
        .e_ready(e_ready), .e_rdata(e_rdata),
        .mem_req(mem_req), .mem_addr(mem_addr), .mem_we(mem_we), .mem_oe(mem_oe),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ready(mem_ready), .owner(owner)
    );

    mem_bus_arbiter #(.EXEC_FIRST(1'b0), .LOCK_TIMEOUT(TMO)) dut_ff (
        .clk(clk), .rst(rst),
        .f_req(b_f_req), .f_addr(b_f_addr), .f_lock(b_f_lock), .f_ready(b_f_ready),
        .f_rdata(b_f_rdata),
        .e_req(b_e_req), .e_addr(b_e_addr), .e_we(b_e_we), .e_wdata(b_e_wdata),
        .e_ready(b_e_ready), .e_rdata(b_e_rdata),
        .mem_req(b_mem_req), .mem_addr(b_mem_addr), .mem_we(b_mem_we), .mem_oe(b_mem_oe),
        .mem_wdata(b_mem_wdata), .mem_rdata(b_mem_rdata), .mem_ready(b_mem_ready),
        .owner(b_owner)
    );

    int n_chk = 0;
    int n_pass = 0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    // Reference model: which port holds the bus, whether a beat is wrapping up, lock bookkeeping.
    int         m_on_bus;      // 0 none, 1 fetch, 2 execute
    bit         m_wrapup;
    bit         m_lock, m_lock_req;
    int         m_idle_cnt;
    logic       m_mem_req, m_mem_we, m_mem_oe, m_f_ready, m_e_ready;
    logic [7:0] m_mem_addr, m_mem_wdata, m_f_rdata, m_e_rdata;
    logic [1:0] m_owner;

    logic [7:0] mem [256];
    int         wait_cnt, lat, fixed_lat;
    bit         rand_mem;

    bit         fp, ep, fl, ew;
    logic [7:0] fa, ea, ed;

    task automatic model_reset();
        m_on_bus = 0; m_wrapup = 0; m_lock = 0; m_lock_req = 0; m_idle_cnt = 0;
        m_mem_req = 0; m_mem_we = 0; m_mem_oe = 0; m_f_ready = 0; m_e_ready = 0;
        m_mem_addr = 8'h00; m_mem_wdata = 8'h00; m_f_rdata = 8'h00; m_e_rdata = 8'h00;
        m_owner = 2'b00; wait_cnt = 0;
    endtask

    task automatic model_next();
        int win;
        win = 0;
        if (!rst) begin
            model_reset();
        end else if (m_wrapup) begin
            m_wrapup = 0; m_f_ready = 0; m_e_ready = 0;
            m_lock = (m_owner == 2'b01) && m_lock_req;
            m_owner = m_lock ? 2'b01 : 2'b00;
        end else if (m_on_bus != 0) begin
            if (mem_ready) begin
                if (m_mem_we) mem[m_mem_addr] = m_mem_wdata;
                else if (m_on_bus == 1) m_f_rdata = mem[m_mem_addr];
                else m_e_rdata = mem[m_mem_addr];
                if (m_on_bus == 1) m_f_ready = 1; else m_e_ready = 1;
                m_mem_req = 0; m_mem_we = 0; m_mem_oe = 0;
                m_on_bus = 0; m_wrapup = 1; wait_cnt = 0;
            end else begin
                wait_cnt++;
            end
        end else begin
            if (m_lock) begin
                if (f_req) win = 1;
                else begin
                    m_idle_cnt++;
                    if (m_idle_cnt == TMO) begin
                        m_lock = 0; m_idle_cnt = 0; m_owner = 2'b00;
                    end
                end
            end else if (f_req && e_req) win = EF ? 2 : 1;
            else if (f_req) win = 1;
            else if (e_req) win = 2;
            if (win == 1) begin
                m_on_bus = 1; m_owner = 2'b01; m_lock_req = f_lock; m_idle_cnt = 0;
                m_mem_req = 1; m_mem_addr = f_addr; m_mem_we = 0; m_mem_oe = 0; m_mem_wdata = 8'h00;
            end else if (win == 2) begin
                m_on_bus = 2; m_owner = 2'b10; m_lock_req = 0;
                m_mem_req = 1; m_mem_addr = e_addr; m_mem_we = e_we; m_mem_oe = e_we;
                m_mem_wdata = e_wdata;
            end
            if (win != 0) begin
                wait_cnt = 0;
                lat = rand_mem ? int'($urandom_range(0, 3)) : fixed_lat;
            end
        end
    endtask

    task automatic drive();
        f_req = fp; f_addr = fa; f_lock = fl;
        e_req = ep; e_addr = ea; e_we = ew; e_wdata = ed;
        if (m_on_bus != 0) begin
            mem_ready = (wait_cnt >= lat);
            mem_rdata = mem[m_mem_addr];
        end else begin
            mem_ready = 1'b0;
            mem_rdata = 8'($urandom);
        end
    endtask

    task automatic compare_all();
        check_val("owner", 32'(owner), 32'(m_owner));
        check_val("mem_req", 32'(mem_req), 32'(m_mem_req));
        check_val("mem_we", 32'(mem_we), 32'(m_mem_we));
        check_val("mem_oe", 32'(mem_oe), 32'(m_mem_oe));
        check_val("mem_addr", 32'(mem_addr), 32'(m_mem_addr));
        check_val("mem_wdata", 32'(mem_wdata), 32'(m_mem_wdata));
        check_val("f_ready", 32'(f_ready), 32'(m_f_ready));
        check_val("e_ready", 32'(e_ready), 32'(m_e_ready));
        check_val("f_rdata", 32'(f_rdata), 32'(m_f_rdata));
        check_val("e_rdata", 32'(e_rdata), 32'(m_e_rdata));
    endtask

    // Called at a falling edge: drive, advance model over the rising edge, compare, return at next fall.
    task automatic tick();
        drive();
        model_next();
        @(posedge clk);
        #1;
        compare_all();
        @(negedge clk);
        if (m_f_ready) fp = 0;
        if (m_e_ready) ep = 0;
    endtask

    task automatic run_window(input int n, output int f_first, output int e_first,
                              output int f_cnt, output int e_cnt);
        f_first = -1; e_first = -1; f_cnt = 0; e_cnt = 0;
        for (int i = 1; i <= n; i++) begin
            tick();
            if (f_ready) begin f_cnt++; if (f_first < 0) f_first = i; end
            if (e_ready) begin e_cnt++; if (e_first < 0) e_first = i; end
        end
    endtask

    int ff, ef, fc, ec, n, bf, be;

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 8'($urandom);
        rst = 1'b0; fp = 0; ep = 0; fl = 0; ew = 0; fa = 8'h00; ea = 8'h00; ed = 8'h00;
        rand_mem = 0; fixed_lat = 0; lat = 0;
        b_f_req = 0; b_f_addr = 8'h00; b_f_lock = 0; b_e_req = 0; b_e_addr = 8'h00;
        b_e_we = 0; b_e_wdata = 8'h00; b_mem_ready = 1'b1; b_mem_rdata = 8'hE7;
        model_reset();
        @(negedge clk);

        // Reset state
        tick(); tick();
        check_val("rst_owner", 32'(owner), 32'd0);
        check_val("rst_mem_req", 32'(mem_req), 32'd0);
        rst = 1'b1;
        tick();

        // Single execute write, memory answers two cycles after mem_req
        fixed_lat = 2; ea = 8'h40; ed = 8'hA5; ew = 1; ep = 1;
        run_window(7, ff, ef, fc, ec);
        check_val("ewr_ready_cycle", 32'(ef), 32'd4);
        check_val("ewr_ready_count", 32'(ec), 32'd1);

        // Simultaneous requests: execute first
        fixed_lat = 1; fa = 8'h20; fl = 0; fp = 1; ea = 8'h21; ew = 0; ep = 1;
        run_window(10, ff, ef, fc, ec);
        check_val("sim_e_first", 32'(ef), 32'd3);
        check_val("sim_f_first", 32'(ff), 32'd7);

        // Locked fetch holds execute off, unlocked fetch releases it
        fixed_lat = 0; mem[8'h10] = 8'h5A; mem[8'h11] = 8'hC3; mem[8'h30] = 8'h77;
        fa = 8'h10; fl = 1; fp = 1;
        tick();
        ea = 8'h30; ew = 0; ep = 1;
        run_window(6, ff, ef, fc, ec);
        check_val("lock_e_held", 32'(ec), 32'd0);
        check_val("lock_owner", 32'(owner), 32'd1);
        check_val("lock_rdata", 32'(f_rdata), 32'h5A);
        fa = 8'h11; fl = 0; fp = 1;
        run_window(8, ff, ef, fc, ec);
        check_val("unlock_f_first", 32'(ff), 32'd2);
        check_val("unlock_e_first", 32'(ef), 32'd5);
        check_val("unlock_f_rdata", 32'(f_rdata), 32'hC3);
        check_val("unlock_e_rdata", 32'(e_rdata), 32'h77);

        // Lock timeout: idle owner loses the bus, pending execute granted on the 9th IDLE cycle
        fa = 8'h12; fl = 1; fp = 1; n = 0;
        while (!f_ready && n < 10) begin tick(); n++; end
        check_val("tmo_f_done", 32'(f_ready), 32'd1);
        ea = 8'h44; ew = 1; ed = 8'h99; ep = 1; n = 0;
        while (!(mem_req && owner == 2'b10) && n < 30) begin tick(); n++; end
        check_val("tmo_grant_cycles", 32'(n), 32'd10);
        run_window(3, ff, ef, fc, ec);

        // Memory ready on the first BUSY cycle
        mem[8'h00] = 8'h3C; fixed_lat = 0; fa = 8'h00; fl = 0; fp = 1; n = 0;
        while (!f_ready && n < 10) begin tick(); n++; end
        check_val("fast_cycles", 32'(n), 32'd2);
        check_val("fast_rdata", 32'(f_rdata), 32'h3C);
        tick();
        check_val("fast_pulse_width", 32'(f_ready), 32'd0);

        // Reset while BUSY aborts the beat
        fixed_lat = 5; ea = 8'h50; ew = 0; ep = 1;
        tick();
        check_val("abort_busy", 32'(mem_req), 32'd1);
        rst = 1'b0;
        tick();
        check_val("abort_mem_req", 32'(mem_req), 32'd0);
        check_val("abort_no_ready", 32'(e_ready), 32'd0);
        rst = 1'b1; ep = 0;
        run_window(3, ff, ef, fc, ec);
        check_val("abort_no_late_ready", 32'(ec), 32'd0);

        // Random traffic against the model
        rand_mem = 1;
        for (int c = 0; c < 3000; c++) begin
            if (!fp && !m_f_ready && $urandom_range(0, 2) == 0) begin
                fa = 8'($urandom); fl = 1'($urandom_range(0, 1)); fp = 1;
            end
            if (!ep && !m_e_ready && $urandom_range(0, 2) == 0) begin
                ea = 8'($urandom); ed = 8'($urandom); ew = 1'($urandom_range(0, 1)); ep = 1;
            end
            rst = ($urandom_range(0, 299) != 0);
            tick();
        end
        rst = 1'b1; fp = 0; ep = 0;
        run_window(12, ff, ef, fc, ec);

        // Fetch-first instance: simultaneous requests grant fetch before execute
        b_f_addr = 8'h01; b_e_addr = 8'h02; b_f_req = 1; b_e_req = 1;
        bf = -1; be = -1;
        for (int i = 1; i <= 12; i++) begin
            @(posedge clk);
            #1;
            if (b_f_ready && bf < 0) bf = i;
            if (b_e_ready && be < 0) be = i;
            @(negedge clk);
            if (b_f_ready) b_f_req = 0;
            if (b_e_ready) b_e_req = 0;
        end
        check_val("ff_f_first", 32'(bf), 32'd2);
        check_val("ff_e_first", 32'(be), 32'd5);
        check_val("ff_f_rdata", 32'(b_f_rdata), 32'hE7);
        check_val("ff_e_rdata", 32'(b_e_rdata), 32'hE7);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
